// File: rtl/dual_mode_processing_element.sv
// Systolic-array processing element: weight-stationary MAC with a double-buffered weight,
// or output-stationary accumulate with drain onto the partial-sum column chain.
module dual_mode_processing_element #(
    parameter int DATA_WIDTH             = 8,
    parameter int ACCUMULATOR_DATA_WIDTH = 32,
    parameter int SATURATE               = 1
) (
    input  logic                                     CLK,
    input  logic                                     ASYNC_RST,
    input  logic                                     SYNC_RST,
    input  logic                                     EN,
    input  logic                                     MODE,
    input  logic                                     LOAD,
    input  logic                                     SWAP,
    input  logic                                     DRAIN,
    input  logic                                     ValidIn,
    input  logic signed [DATA_WIDTH-1:0]             Input,
    input  logic signed [DATA_WIDTH-1:0]             WeightIn,
    input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] PsumIn,
    output logic signed [DATA_WIDTH-1:0]             ToRight,
    output logic signed [DATA_WIDTH-1:0]             WeightDown,
    output logic signed [ACCUMULATOR_DATA_WIDTH-1:0] PsumOut,
    output logic                                     ValidOut,
    output logic                                     ShadowFull,
    output logic                                     Overflow
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ACCUMULATOR_DATA_WIDTH;

    logic signed [DW-1:0]   active_w;
    logic signed [DW-1:0]   shadow_w;
    logic signed [AW-1:0]   acc;
    logic                   mode_q;

    logic signed [2*DW-1:0] ws_prod;
    logic signed [2*DW-1:0] os_prod;
    logic signed [AW-1:0]   acc_base;
    logic signed [AW-1:0]   os_add_base;
    logic        [AW:0]     ws_res;
    logic        [AW:0]     os_res;
    logic                   compute;

    // Sign-extend a full-width product into the guard-bit adder width.
    function automatic logic signed [AW:0] ext_prod(input logic signed [2*DW-1:0] p);
        return {{(AW+1-2*DW){p[2*DW-1]}}, p};
    endfunction

    // Returns {overflow, result}: clamp or wrap the guard-bit sum back into AW bits.
    function automatic logic [AW:0] fix_sum(input logic signed [AW:0] s);
        logic          ovf;
        logic [AW-1:0] v;
        ovf = s[AW] ^ s[AW-1];
        if (ovf && (SATURATE != 0))
            v = s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        else
            v = s[AW-1:0];
        return {ovf, v};
    endfunction

    assign ws_prod     = Input * active_w;
    assign os_prod     = Input * WeightIn;
    assign compute     = ValidIn & ~LOAD;
    assign acc_base    = (MODE != mode_q) ? '0 : acc;
    // A drain restarts accumulation from the current product alone.
    assign os_add_base = DRAIN ? '0 : acc_base;
    assign ws_res      = fix_sum({PsumIn[AW-1], PsumIn} + ext_prod(ws_prod));
    assign os_res      = fix_sum({os_add_base[AW-1], os_add_base} + ext_prod(os_prod));

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            ToRight    <= '0;
            WeightDown <= '0;
            PsumOut    <= '0;
            ValidOut   <= 1'b0;
            ShadowFull <= 1'b0;
            Overflow   <= 1'b0;
            acc        <= '0;
            active_w   <= '0;
            shadow_w   <= '0;
            mode_q     <= 1'b0;
        end else if (SYNC_RST) begin
            ToRight    <= '0;
            WeightDown <= '0;
            PsumOut    <= '0;
            ValidOut   <= 1'b0;
            ShadowFull <= 1'b0;
            Overflow   <= 1'b0;
            acc        <= '0;
            active_w   <= '0;
            shadow_w   <= '0;
            mode_q     <= 1'b0;
        end else if (EN) begin
            mode_q   <= MODE;
            ValidOut <= compute;

            // Swap before load so a simultaneous LOAD+SWAP promotes the old shadow.
            if (SWAP && ShadowFull) begin
                active_w   <= shadow_w;
                ShadowFull <= 1'b0;
            end
            if (LOAD) begin
                shadow_w   <= Input;
                ShadowFull <= 1'b1;
            end

            if (!MODE) begin
                acc <= acc_base;
                if (compute) begin
                    PsumOut    <= ws_res[AW-1:0];
                    ToRight    <= Input;
                    WeightDown <= active_w;
                    if (ws_res[AW])
                        Overflow <= 1'b1;
                end
            end else begin
                PsumOut <= DRAIN ? acc_base : PsumIn;
                if (compute) begin
                    ToRight    <= Input;
                    WeightDown <= WeightIn;
                    acc        <= os_res[AW-1:0];
                    if (os_res[AW])
                        Overflow <= 1'b1;
                end else begin
                    acc <= DRAIN ? '0 : acc_base;
                end
            end
        end
    end

endmodule

// File: tb/tb_dual_mode_processing_element.sv
// Directed bench: WS/OS dataflow, weight double buffering, resets, enable hold and
// saturating vs wrapping 16-bit accumulation.
module tb_dual_mode_processing_element;

    logic clk = 1'b0;
    logic rst_n, sync_rst, en, mode, load, swap, drain, valid_in;
    logic signed [7:0]  in_act, weight_in;
    logic signed [31:0] psum_in;
    logic signed [15:0] psum_in16;

    logic signed [7:0]  to_right, weight_down;
    logic signed [31:0] psum_out;
    logic               valid_out, shadow_full, overflow;

    logic signed [7:0]  sat_tr, sat_wd, wrp_tr, wrp_wd;
    logic signed [15:0] sat_psum, wrp_psum;
    logic               sat_vo, sat_sf, sat_ovf, wrp_vo, wrp_sf, wrp_ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    assign psum_in16 = psum_in[15:0];

    always #5 clk = ~clk;

    dual_mode_processing_element #(.DATA_WIDTH(8), .ACCUMULATOR_DATA_WIDTH(32), .SATURATE(1)) dut (
        .CLK(clk), .ASYNC_RST(rst_n), .SYNC_RST(sync_rst), .EN(en), .MODE(mode),
        .LOAD(load), .SWAP(swap), .DRAIN(drain), .ValidIn(valid_in),
        .Input(in_act), .WeightIn(weight_in), .PsumIn(psum_in),
        .ToRight(to_right), .WeightDown(weight_down), .PsumOut(psum_out),
        .ValidOut(valid_out), .ShadowFull(shadow_full), .Overflow(overflow)
    );

    dual_mode_processing_element #(.DATA_WIDTH(8), .ACCUMULATOR_DATA_WIDTH(16), .SATURATE(1)) dut_sat (
        .CLK(clk), .ASYNC_RST(rst_n), .SYNC_RST(sync_rst), .EN(en), .MODE(mode),
        .LOAD(load), .SWAP(swap), .DRAIN(drain), .ValidIn(valid_in),
        .Input(in_act), .WeightIn(weight_in), .PsumIn(psum_in16),
        .ToRight(sat_tr), .WeightDown(sat_wd), .PsumOut(sat_psum),
        .ValidOut(sat_vo), .ShadowFull(sat_sf), .Overflow(sat_ovf)
    );

    dual_mode_processing_element #(.DATA_WIDTH(8), .ACCUMULATOR_DATA_WIDTH(16), .SATURATE(0)) dut_wrap (
        .CLK(clk), .ASYNC_RST(rst_n), .SYNC_RST(sync_rst), .EN(en), .MODE(mode),
        .LOAD(load), .SWAP(swap), .DRAIN(drain), .ValidIn(valid_in),
        .Input(in_act), .WeightIn(weight_in), .PsumIn(psum_in16),
        .ToRight(wrp_tr), .WeightDown(wrp_wd), .PsumOut(wrp_psum),
        .ValidOut(wrp_vo), .ShadowFull(wrp_sf), .Overflow(wrp_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag,
                     $signed(got), got, $signed(exp), exp);
        end
    endtask

    // One clock edge, then settle; prints one line per transaction.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d en=%0b mode=%0b ld=%0b sw=%0b dr=%0b v=%0b in=%0d w=%0d pin=%0d -> psum=%0d tr=%0d wd=%0d vo=%0b sf=%0b ovf=%0b",
                 cyc, en, mode, load, swap, drain, valid_in, in_act, weight_in, psum_in,
                 psum_out, to_right, weight_down, valid_out, shadow_full, overflow);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psum"}, psum_out, 0);
        chk({tag, "_tr"}, to_right, 0);
        chk({tag, "_wd"}, weight_down, 0);
        chk({tag, "_vo"}, valid_out, 0);
        chk({tag, "_sf"}, shadow_full, 0);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        rst_n = 0; sync_rst = 0; en = 0; mode = 0; load = 0; swap = 0; drain = 0;
        valid_in = 0; in_act = 0; weight_in = 0; psum_in = 0;
        #3;
        chk_all_zero("reset");
        #5 rst_n = 1;

        // Weight-stationary: load 50, swap, compute 1 + 4*50
        en = 1; load = 1; in_act = 50;
        step(); chk("ws_load_sf", shadow_full, 1); chk("ws_load_vo", valid_out, 0);
        load = 0; swap = 1;
        step(); chk("ws_swap_sf", shadow_full, 0);
        swap = 0; valid_in = 1; in_act = 4; psum_in = 1;
        step();
        chk("ws_psum", psum_out, 201); chk("ws_tr", to_right, 4);
        chk("ws_wd", weight_down, 50); chk("ws_vo", valid_out, 1);

        // Double buffering: LOAD with ValidIn does not compute
        load = 1; in_act = 3; valid_in = 1;
        step();
        chk("db_load_vo", valid_out, 0); chk("db_load_tr", to_right, 4);
        chk("db_load_sf", shadow_full, 1); chk("db_load_psum", psum_out, 201);
        load = 0; in_act = 2; psum_in = 10;
        step(); chk("db_old_w", psum_out, 110);
        swap = 1;
        step(); chk("db_swap_cycle", psum_out, 110); chk("db_swap_sf", shadow_full, 0);
        swap = 0;
        step(); chk("db_new_w", psum_out, 16); chk("db_new_wd", weight_down, 3);

        // Async reset mid-compute
        load = 1; in_act = 7; valid_in = 0;
        step(); chk("ar_pre_sf", shadow_full, 1);
        load = 0; valid_in = 1; in_act = 5; psum_in = 0;
        #2 rst_n = 0;
        #1 chk_all_zero("async");
        rst_n = 1;
        step(); chk("ar_resume_tr", to_right, 5); chk("ar_resume_psum", psum_out, 0);

        // Output-stationary: 2*3 + 4*5 + (-1)*7 = 19
        mode = 1; valid_in = 1; psum_in = 77; in_act = 2; weight_in = 3;
        step();
        chk("os_shift_psum", psum_out, 77); chk("os_wd", weight_down, 3); chk("os_tr", to_right, 2);
        in_act = 4; weight_in = 5;
        step();
        in_act = -1; weight_in = 7;
        step(); chk("os_wd_neg", weight_down, 7); chk("os_tr_neg", to_right, -1);
        drain = 1; valid_in = 0;
        step(); chk("os_drain", psum_out, 19); chk("os_drain_vo", valid_out, 0);
        step(); chk("os_acc_cleared", psum_out, 0);
        drain = 0; valid_in = 1; in_act = 3; weight_in = 3; psum_in = 5;
        step(); chk("os_shift2", psum_out, 5);
        drain = 1; in_act = 2; weight_in = 2;
        step(); chk("os_drain_valid", psum_out, 9); chk("os_drain_valid_vo", valid_out, 1);
        valid_in = 0;
        step(); chk("os_drain_keep_prod", psum_out, 4);
        chk("os_no_ovf", overflow, 0);

        // Enable hold, then synchronous clear
        drain = 0; valid_in = 1; in_act = 2; weight_in = 3; psum_in = 5;
        step();
        en = 0; in_act = 99; weight_in = 9; psum_in = 123; load = 1; valid_in = 0; drain = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_psum", psum_out, 5); chk("hold_tr", to_right, 2);
            chk("hold_wd", weight_down, 3); chk("hold_vo", valid_out, 1);
            chk("hold_sf", shadow_full, 0);
        end
        sync_rst = 1;
        step(); chk_all_zero("sync");

        // Saturation vs wrap at 16 bits
        sync_rst = 0; en = 1; mode = 0; drain = 0; load = 1; in_act = 1; valid_in = 0;
        step();
        load = 0; swap = 1;
        step();
        swap = 0; valid_in = 1; in_act = 1; psum_in = 32767;
        step();
        chk("sat_pos_psum", sat_psum, 32767); chk("sat_pos_ovf", sat_ovf, 1);
        chk("wrap_pos_psum", wrp_psum, -32768); chk("wrap_pos_ovf", wrp_ovf, 1);
        chk("wide_psum", psum_out, 32768); chk("wide_ovf", overflow, 0);
        in_act = -1; psum_in = -32768;
        step();
        chk("sat_neg_psum", sat_psum, -32768); chk("wrap_neg_psum", wrp_psum, 32767);
        chk("wide_neg_psum", psum_out, -32769);
        in_act = 1; psum_in = 100;
        step(); chk("sat_normal", sat_psum, 101); chk("sat_ovf_sticky", sat_ovf, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
